// File: rtl/cardinal_run_monitor_if.sv
// cardinal_run_monitor_if: DMEM read bus and dump stream between the run monitor and the harness.
interface cardinal_run_monitor_if #(
  parameter int NODES   = 4,
  parameter int DATA_W  = 64,
  parameter int DADDR_W = 8
);
  localparam int NW = (NODES > 1) ? $clog2(NODES) : 1;
  logic              dmem_rd;
  logic [NW-1:0]     dmem_node;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_data;
  logic              out_valid;
  logic              out_ready;
  logic [NW-1:0]     out_node;
  logic [DADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  modport master (
    output dmem_rd, dmem_node, dmem_addr, out_valid, out_node, out_addr, out_data,
    input  dmem_data, out_ready
  );
  modport slave (
    input  dmem_rd, dmem_node, dmem_addr, out_valid, out_node, out_addr, out_data,
    output dmem_data, out_ready
  );
endinterface

// File: rtl/cardinal_run_monitor.sv
// cardinal_run_monitor: watches node instruction buses for the final NOP, drains, then dumps every DMEM.
// Optional PER_NODE_CYCLES_EN builds per-node completion-cycle latches on o_node_cycles.
module cardinal_run_monitor #(
  parameter int NODES        = 4,
  parameter int INST_W       = 32,
  parameter int DATA_W       = 64,
  parameter int DADDR_W      = 8,
  parameter int DUMP_DEPTH   = 128,
  parameter int DRAIN_CYCLES = 5,
  parameter int CYC_W        = 32,
  parameter int MAX_CYCLES   = 500
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [NODES*INST_W-1:0] i_inst,
  cardinal_run_monitor_if.master  bus,
  output logic [CYC_W-1:0]        o_cycle_count,
  output logic [NODES-1:0]        o_done_mask,
  output logic                    o_timeout,
  output logic                    o_busy,
  output logic                    o_all_done,
  output logic [NODES*CYC_W-1:0]  o_node_cycles
);
  localparam int NW = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DUMP, DONE} state_t;
  typedef struct packed {
    logic [NW-1:0]      n;
    logic [DADDR_W-1:0] a;
    logic [DATA_W-1:0]  d;
  } word_t;
  state_t             r_state;
  logic [CYC_W-1:0]   r_cnt;
  logic [NODES-1:0]   r_mask;
  logic               r_to;
  logic [DW-1:0]      r_drain;
  logic [NW-1:0]      r_rn, r_pn;
  logic [DADDR_W-1:0] r_ra, r_pa;
  logic               r_rd_end, r_pend;
  logic [1:0]         r_occ;
  word_t              r_b0, r_b1;
  logic [NODES-1:0]   w_zero, w_mask;
  logic               w_all, w_tmo, w_pop, w_issue, w_last, w_ra_end;
  logic [2:0]         w_occ;
  word_t              w_in;
  for (genvar n = 0; n < NODES; n++) begin : g_zero
    assign w_zero[n] = i_inst[n*INST_W +: INST_W] == '0;
  end
  always_comb begin
    w_mask   = r_mask | w_zero;
    w_all    = &w_mask;
    w_tmo    = r_cnt == CYC_W'(MAX_CYCLES - 1);
    w_pop    = (r_occ != 2'd0) && bus.out_ready;
    w_in     = {r_pn, r_pa, bus.dmem_data};
    // words buffered after this edge, counting the one landing now; a new read needs one free slot
    w_occ    = {1'b0, r_occ} - {2'b0, w_pop} + {2'b0, r_pend};
    w_issue  = (r_state == DUMP) && !r_rd_end && (w_occ < 3'd2);
    w_ra_end = r_ra == DADDR_W'(DUMP_DEPTH - 1);
    w_last   = w_pop && (r_b0.n == NW'(NODES - 1)) && (r_b0.a == DADDR_W'(DUMP_DEPTH - 1));
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mask   <= '0;
      r_to     <= 1'b0;
      r_drain  <= '0;
      r_rn     <= '0;
      r_ra     <= '0;
      r_pn     <= '0;
      r_pa     <= '0;
      r_rd_end <= 1'b0;
      r_pend   <= 1'b0;
      r_occ    <= '0;
      r_b0     <= '0;
      r_b1     <= '0;
    end else begin
      r_pend <= w_issue;
      r_pn   <= r_rn;
      r_pa   <= r_ra;
      r_occ  <= w_occ[1:0];
      if (r_pend && (r_occ == 2'd0 || (w_pop && r_occ == 2'd1))) r_b0 <= w_in;
      else if (w_pop && r_occ == 2'd2) r_b0 <= r_b1;
      if (r_pend) r_b1 <= w_in;
      if (w_issue) begin
        r_ra <= w_ra_end ? '0 : r_ra + 1'b1;
        if (w_ra_end && r_rn == NW'(NODES - 1)) r_rd_end <= 1'b1;
        else if (w_ra_end) r_rn <= r_rn + 1'b1;
      end
      case (r_state)
        IDLE, DONE: if (i_start) begin
          r_state  <= RUN;
          r_cnt    <= '0;
          r_mask   <= '0;
          r_to     <= 1'b0;
          r_rn     <= '0;
          r_ra     <= '0;
          r_rd_end <= 1'b0;
        end
        RUN: begin
          r_mask <= w_mask;
          if (w_all || w_tmo) begin
            r_state <= DRAIN;
            r_to    <= !w_all;
            r_drain <= '0;
          end else r_cnt <= r_cnt + 1'b1;
        end
        DRAIN: begin
          r_drain <= r_drain + 1'b1;
          if (r_drain == DW'(DRAIN_CYCLES - 1)) r_state <= DUMP;
        end
        DUMP: if (w_last) r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef PER_NODE_CYCLES_EN
  logic [NODES*CYC_W-1:0] r_nc;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_nc <= '0;
    else if ((r_state == IDLE || r_state == DONE) && i_start) r_nc <= '0;
    else if (r_state == RUN)
      for (int k = 0; k < NODES; k++)
        if (w_zero[k] && !r_mask[k]) r_nc[k*CYC_W +: CYC_W] <= r_cnt;
  end
  assign o_node_cycles = r_nc;
`else
  assign o_node_cycles = '0;
`endif
  assign bus.dmem_rd   = w_issue;
  assign bus.dmem_node = w_issue ? r_rn : '0;
  assign bus.dmem_addr = w_issue ? r_ra : '0;
  assign bus.out_valid = r_occ != 2'd0;
  assign bus.out_node  = r_b0.n;
  assign bus.out_addr  = r_b0.a;
  assign bus.out_data  = r_b0.d;
  assign o_cycle_count = r_cnt;
  assign o_done_mask   = r_mask;
  assign o_timeout     = r_to;
  assign o_busy        = r_state inside {RUN, DRAIN, DUMP};
  assign o_all_done    = r_state == DONE;
endmodule

// File: tb/tb_cardinal_run_monitor.sv
// tb_cardinal_run_monitor: randomized runs and dumps checked against a completion-time model and a DMEM array.
module tb_cardinal_run_monitor;
  localparam int MAXC = 500;
  localparam int NEVER = 1000;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] inst;
  logic [31:0]  cyc_cnt;
  logic [3:0]   mask;
  logic         tmo, busy, all_done;
  logic [127:0] node_cyc;
  logic [63:0]  mem [4][128];
  int           checks = 0;
  int           errors = 0;
  cardinal_run_monitor_if bus ();
  cardinal_run_monitor dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_inst(inst), .bus(bus),
    .o_cycle_count(cyc_cnt), .o_done_mask(mask), .o_timeout(tmo), .o_busy(busy),
    .o_all_done(all_done), .o_node_cycles(node_cyc)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    bus.dmem_data <= bus.dmem_rd ? mem[bus.dmem_node][bus.dmem_addr[6:0]] : {$urandom, $urandom};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_cnt"}, 64'(cyc_cnt), 0);
    chk({tag, "_flags"}, {mask, tmo, busy, all_done, bus.out_valid, bus.dmem_rd}, 0);
    chk({tag, "_tags"}, {bus.out_node, bus.out_addr, bus.dmem_node, bus.dmem_addr}, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_ncyc"}, 64'(node_cyc != '0), 0);
  endtask
  task automatic run(input int t0, input int t1, input int t2, input int t3, input int pct, input bit abort);
    int t[4];
    int mx, e, acc, rd, cyc, outst;
    logic [3:0] m;
    bit pv, pr;
    logic [9:0] ptag;
    logic [63:0] pd, ne;
    t = '{t0, t1, t2, t3};
    mx = 0;
    for (int n = 0; n < 4; n++) mx = (t[n] > mx) ? t[n] : mx;
    e = (mx <= MAXC - 1) ? mx : MAXC - 1;
    for (int n = 0; n < 4; n++) m[n] = t[n] <= e;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= e; k++) begin
      for (int n = 0; n < 4; n++)
        inst[n*32 +: 32] = (k == t[n]) ? 32'd0 : (k > t[n] && $urandom_range(0, 3) == 0) ? 32'd0 : ($urandom | 32'd1);
      start = $urandom_range(0, 15) == 0;
      chk("run_cnt", 64'(cyc_cnt), 64'(k));
      if (k == 0) begin
        chk("start_clr_mask", 64'(mask), 0);
        chk("start_clr_tmo", 64'(tmo), 0);
        chk("start_clr_ncyc", 64'(node_cyc != '0), 0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    inst = '0;
    chk("end_cnt", 64'(cyc_cnt), 64'(e));
    chk("end_mask", 64'(mask), 64'(m));
    chk("end_tmo", 64'(tmo), 64'(mx > MAXC - 1));
    chk("drain_busy", {busy, all_done}, 2'b10);
    for (int n = 0; n < 4; n++) begin
`ifdef PER_NODE_CYCLES_EN
      ne = (t[n] <= e) ? 64'(t[n]) : 0;
`else
      ne = 0;
`endif
      chk("node_cycles", 64'(node_cyc[n*32 +: 32]), ne);
    end
    for (int d = 0; d < 5; d++) begin
      chk("drain_rd", 64'(bus.dmem_rd), 0);
      @(negedge clk);
    end
    chk("drain_hold_mask", 64'(mask), 64'(m));
    acc = 0; rd = 0; cyc = 0; pv = 0; pr = 0; ptag = '0; pd = '0;
    while (acc < 512 && cyc < 8000) begin
      if (abort && acc == 200) begin
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      bus.out_ready = $urandom_range(0, 99) < pct;
      start = (acc < 500) && ($urandom_range(0, 15) == 0);
      #1;
      if (cyc == 0) chk("first_rd", 64'(bus.dmem_rd), 1);
      if (pv && !pr) begin
        chk("hold_valid", 64'(bus.out_valid), 1);
        chk("hold_tag", 64'({bus.out_node, bus.out_addr}), 64'(ptag));
        chk("hold_data", bus.out_data, pd);
      end
      if (pct == 100 && acc > 0) chk("tput", 64'(bus.out_valid), 1);
      outst = rd - acc - int'(bus.out_valid && bus.out_ready);
      if (bus.dmem_rd) begin
        chk("rd_room", 64'(outst < 2), 1);
        chk("rd_tag", 64'({bus.dmem_node, bus.dmem_addr}), 64'({2'(rd / 128), 8'(rd % 128)}));
        rd++;
      end else chk("rd_idle", 64'({bus.dmem_node, bus.dmem_addr}), 0);
      if (bus.out_valid && bus.out_ready) begin
        chk("out_tag", 64'({bus.out_node, bus.out_addr}), 64'({2'(acc / 128), 8'(acc % 128)}));
        chk("out_data", bus.out_data, mem[acc / 128][acc % 128]);
        acc++;
      end
      pv = bus.out_valid; pr = bus.out_ready;
      ptag = {bus.out_node, bus.out_addr}; pd = bus.out_data;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("dump_words", 64'(acc), 512);
    chk("dump_reads", 64'(rd), 512);
    chk("done_flags", {all_done, busy, bus.out_valid, bus.dmem_rd}, 4'b1000);
    chk("done_cnt", 64'(cyc_cnt), 64'(e));
    chk("done_mask", 64'(mask), 64'(m));
  endtask
  initial begin
    for (int n = 0; n < 4; n++)
      for (int a = 0; a < 128; a++) mem[n][a] = {16'(n), 16'(a), $urandom};
    rst_n = 1'b0; start = 1'b0; inst = '0; bus.out_ready = 1'b0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run(10, 20, 30, 40, 100, 0);
    run(15, 25, NEVER, 35, 30, 0);
    run($urandom_range(1, 450), $urandom_range(1, 450), $urandom_range(1, 450), $urandom_range(1, 450), 30, 1);
    chk_zero("post_abort");
    run($urandom_range(1, 450), $urandom_range(1, 450), $urandom_range(1, 450), $urandom_range(1, 450), 30, 0);
    run($urandom_range(1, 450), NEVER, $urandom_range(1, 450), $urandom_range(1, 450), 60, 0);
    run(NEVER, NEVER, NEVER, NEVER, 80, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
